// File: rtl/uart_sender.sv
// UART transmitter: 8 data bits, no parity, one or two stop bits, LSB first.
// BaudRate runs at OVERSAMPLE times the serial bit rate; every bit lasts OVERSAMPLE cycles.
module uart_sender #(
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic       BaudRate,
  input  logic       reset,
  input  logic [7:0] TXData,
  input  logic       TXEn,
  output logic       TXStatus,
  output logic       UART_TX
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [3:0] TICK_MAX  = 4'(OVERSAMPLE - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  state_t     r_state;
  logic [3:0] r_tick;
  logic [2:0] r_bitIdx;
  logic [7:0] r_shift;
  logic       r_stopCnt;
  logic       r_tx;
  logic       r_status;
  logic       w_tickDone;

  assign w_tickDone = (r_tick == TICK_MAX);
  assign UART_TX    = r_tx;
  assign TXStatus   = r_status;

  // Each transition loads the value the line must carry for the next bit,
  // so UART_TX changes on exactly the edge that enters the new bit.
  always_ff @(posedge BaudRate or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_tick    <= 4'd0;
      r_bitIdx  <= 3'd0;
      r_shift   <= 8'h00;
      r_stopCnt <= 1'b0;
      r_tx      <= 1'b1;
      r_status  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (TXEn) begin
            r_shift   <= TXData;
            r_tick    <= 4'd0;
            r_bitIdx  <= 3'd0;
            r_stopCnt <= 1'b0;
            r_tx      <= 1'b0;
            r_status  <= 1'b0;
            r_state   <= START;
          end
        end
        START: begin
          if (w_tickDone) begin
            r_tick   <= 4'd0;
            r_bitIdx <= 3'd0;
            r_tx     <= r_shift[0];
            r_state  <= DATA;
          end else begin
            r_tick <= r_tick + 4'd1;
          end
        end
        DATA: begin
          if (w_tickDone) begin
            r_tick  <= 4'd0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bitIdx == 3'd7) begin
              r_tx      <= 1'b1;
              r_stopCnt <= 1'b0;
              r_state   <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_tx     <= r_shift[1];
            end
          end else begin
            r_tick <= r_tick + 4'd1;
          end
        end
        STOP: begin
          if (w_tickDone) begin
            r_tick <= 4'd0;
            if (r_stopCnt == STOP_LAST) begin
              r_status <= 1'b1;
              r_state  <= IDLE;
            end else begin
              r_stopCnt <= r_stopCnt + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 4'd1;
          end
        end
        default: begin
          r_tx     <= 1'b1;
          r_status <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// Scoreboard bench for uart_sender at default parameters: stimulus pushes expected
// frames, a line monitor decodes UART_TX and checks bytes, timing and busy length.
module tb_uart_sender;

  logic       BaudRate = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] TXData = 8'h00;
  logic       TXEn = 1'b0;
  logic       TXStatus;
  logic       UART_TX;

  typedef struct {
    logic [7:0] data;
    int         acceptEdge;
  } expFrame_t;

  expFrame_t  sbQ[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         inFrame = 1'b0;
  int         startEdge = 0;
  int         offset = 0;
  int         bitNum = 0;
  int         framesSeen = 0;
  int         runLen = 0;
  logic [7:0] rxByte = 8'h00;
  expFrame_t  popped;

  uart_sender dut (
    .BaudRate(BaudRate),
    .reset(reset),
    .TXData(TXData),
    .TXEn(TXEn),
    .TXStatus(TXStatus),
    .UART_TX(UART_TX)
  );

  always #5 BaudRate = ~BaudRate;

  // cyc holds the index of the most recent rising edge
  always @(posedge BaudRate) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] holdData,
                               input bit expectIt, output int acceptEdge);
    int guard = 0;
    while (TXStatus !== 1'b1 && guard < 400) begin
      @(posedge BaudRate); #1;
      guard++;
    end
    checkOutput("readyBeforeSend", {31'd0, TXStatus}, 32'd1);
    TXData = data;
    TXEn = 1'b1;
    acceptEdge = cyc + 1;
    if (expectIt) sbQ.push_back('{data, acceptEdge});
    @(posedge BaudRate); #1;
    TXEn = 1'b0;
    TXData = holdData;
    checkOutput("acceptStatusLow", {31'd0, TXStatus}, 32'd0);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge BaudRate); #1;
    end
  endtask

  // Line monitor: samples each bit at its centre, compares finished frames against the scoreboard.
  always @(negedge BaudRate) begin
    if (!reset) begin
      inFrame = 1'b0;
      runLen = 0;
    end else begin
      if (!inFrame && UART_TX === 1'b0) begin
        inFrame = 1'b1;
        startEdge = cyc;
      end
      if (inFrame) begin
        offset = cyc - startEdge;
        if (offset % 16 == 8) begin
          bitNum = offset / 16;
          if (bitNum == 0) begin
            checkOutput("startBit", {31'd0, UART_TX}, 32'd0);
          end else if (bitNum <= 8) begin
            rxByte[bitNum-1] = UART_TX;
          end else begin
            checkOutput("stopBit", {31'd0, UART_TX}, 32'd1);
            framesSeen++;
            if (sbQ.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpectedFrame: got byte %0h expected no frame", rxByte);
            end else begin
              popped = sbQ.pop_front();
              checkOutput("frameData", {24'd0, rxByte}, {24'd0, popped.data});
              checkOutput("startEdge", startEdge, popped.acceptEdge);
            end
            inFrame = 1'b0;
          end
        end
      end
      if (TXStatus === 1'b0) begin
        runLen++;
      end else if (runLen > 0) begin
        checkOutput("busyCycles", runLen, 32'd160);
        runLen = 0;
      end
    end
  end

  initial begin
    int k;
    int k2;
    int bad;
    int releaseEdge;
    int guard;

    // Asynchronous reset before any clock edge
    #2 reset = 1'b0;
    #1;
    checkOutput("resetLine", {31'd0, UART_TX}, 32'd1);
    checkOutput("resetStatus", {31'd0, TXStatus}, 32'd1);
    repeat (3) @(posedge BaudRate);
    #1 reset = 1'b1;

    bad = 0;
    repeat (500) begin
      @(negedge BaudRate);
      if (UART_TX !== 1'b1 || TXStatus !== 1'b1) bad++;
    end
    checkOutput("idle500", bad, 32'd0);
    @(posedge BaudRate); #1;

    applyStimulus(8'h55, 8'h55, 1'b1, k);
    applyStimulus(8'hA3, 8'hFF, 1'b1, k);

    // Requests while busy and on the edge that returns to idle are dropped
    applyStimulus(8'h0F, 8'h0F, 1'b1, k);
    waitUntil(k + 79);
    TXData = 8'hF0;
    TXEn = 1'b1;
    @(posedge BaudRate); #1;
    TXEn = 1'b0;
    waitUntil(k + 159);
    TXEn = 1'b1;
    @(posedge BaudRate); #1;
    TXEn = 1'b0;
    checkOutput("statusAtReturn", {31'd0, TXStatus}, 32'd1);
    bad = 0;
    repeat (20) begin
      @(posedge BaudRate); #1;
      if (TXStatus !== 1'b1 || UART_TX !== 1'b1) bad++;
    end
    checkOutput("busyReqIgnored", bad, 32'd0);

    applyStimulus(8'h3C, 8'h3C, 1'b1, k);
    applyStimulus(8'hC3, 8'hC3, 1'b1, k2);
    checkOutput("backToBackEdge", k2, k + 161);

    // Reset in the middle of data bit 3 of 8'h81 (a zero bit)
    applyStimulus(8'h81, 8'h81, 1'b0, k);
    waitUntil(k + 70);
    checkOutput("lineBeforeReset", {31'd0, UART_TX}, 32'd0);
    #2 reset = 1'b0;
    #1;
    checkOutput("abortLine", {31'd0, UART_TX}, 32'd1);
    checkOutput("abortStatus", {31'd0, TXStatus}, 32'd1);
    TXEn = 1'b1;
    TXData = 8'h11;
    repeat (3) @(posedge BaudRate);
    #1;
    checkOutput("txEnInReset", {30'd0, TXStatus, UART_TX}, 32'd3);
    TXEn = 1'b0;
    reset = 1'b1;
    releaseEdge = cyc;
    applyStimulus(8'h7E, 8'h7E, 1'b1, k);
    checkOutput("acceptAfterRelease", k, releaseEdge + 1);

    guard = 0;
    while ((sbQ.size() != 0 || inFrame || runLen != 0) && guard < 400) begin
      @(posedge BaudRate); #1;
      guard++;
    end
    checkOutput("drainTimeout", {31'd0, guard >= 400}, 32'd0);
    checkOutput("queueEmpty", sbQ.size(), 32'd0);
    checkOutput("framesSeen", framesSeen, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
